// File: rtl/scan_pkg.sv
// Shared types and sizing for the truth-table scanner slice.
package scan_pkg;

   localparam int unsigned VEC_W   = 4;
   localparam int unsigned NUM_VEC = 16;
   localparam int unsigned CNT_W   = 4;
   localparam int unsigned ERR_W   = 5;

   localparam logic [NUM_VEC-1:0] GOLDEN_TT = 16'h32A4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } scan_state_t;

endpackage

// File: rtl/truth_table_scanner_if.sv
// Control, status and function-block signals of the truth-table scanner.
interface truth_table_scanner_if;
   import scan_pkg::*;

   logic               start;
   logic               f_in;
   logic               x;
   logic               y;
   logic               z;
   logic               w;
   logic               busy;
   logic               done;
   logic [NUM_VEC-1:0] table_out;
   logic [ERR_W-1:0]   err_count;
   logic               pass;

   modport master (
      input  start, f_in,
      output x, y, z, w, busy, done, table_out, err_count, pass
   );

   modport slave (
      output start, f_in,
      input  x, y, z, w, busy, done, table_out, err_count, pass
   );

endinterface

// File: rtl/scan_settle_timer.sv
// Load/enable up-counter; tc is high on the enabled cycle that reaches 'last'.
module scan_settle_timer
   import scan_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             en,
   input  logic [CNT_W-1:0] last,
   output logic             tc
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc = en && (cnt_q == last);

endmodule

// File: rtl/truth_table_scanner.sv
// Drives all 16 {x,y,z,w} vectors, captures f_in into a truth table and grades it.
// Optional build macro SCAN_ABORT_ON_MISMATCH_EN: stop the scan at the first mismatch.
module truth_table_scanner
   import scan_pkg::*;
#(
   parameter int unsigned        SETTLE_CYCLES = 2,
   parameter logic [NUM_VEC-1:0] EXPECTED      = GOLDEN_TT
) (
   input  logic                  clk,
   input  logic                  rst,
   truth_table_scanner_if.master bus
);

   if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
      $error("truth_table_scanner: SETTLE_CYCLES must be in 1..15");
   end

   scan_state_t        state_q, state_d;
   logic [VEC_W-1:0]   idx_q, idx_d;
   logic [NUM_VEC-1:0] table_q, table_d;
   logic [ERR_W-1:0]   err_q, err_d;
   logic               pass_q, pass_d;

   logic               tmr_load;
   logic               tmr_en;
   logic               tmr_tc;
   logic               mismatch;
   logic               in_scan;

   scan_settle_timer u_timer (
      .clk  (clk),
      .rst  (rst),
      .load (tmr_load),
      .en   (tmr_en),
      .last (CNT_W'(SETTLE_CYCLES - 1)),
      .tc   (tmr_tc)
   );

   assign mismatch = (bus.f_in != EXPECTED[idx_q]);

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      table_d  = table_q;
      err_d    = err_q;
      pass_d   = pass_q;
      tmr_load = 1'b0;
      tmr_en   = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d  = SETTLE;
               idx_d    = '0;
               table_d  = '0;
               err_d    = '0;
               pass_d   = 1'b0;
               tmr_load = 1'b1;
            end
         end
         SETTLE: begin
            tmr_en = 1'b1;
            if (tmr_tc) begin
               state_d = SAMPLE;
            end
         end
         SAMPLE: begin
            table_d[idx_q] = bus.f_in;
            if (mismatch) begin
               err_d = err_q + ERR_W'(1);
            end
`ifdef SCAN_ABORT_ON_MISMATCH_EN
            if (mismatch || idx_q == VEC_W'(NUM_VEC - 1)) begin
`else
            if (idx_q == VEC_W'(NUM_VEC - 1)) begin
`endif
               state_d = DONE;
               // Grade with the count that includes this final sample.
               pass_d  = (err_d == '0);
            end else begin
               idx_d    = idx_q + VEC_W'(1);
               tmr_load = 1'b1;
               state_d  = SETTLE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         table_q <= '0;
         err_q   <= '0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         table_q <= table_d;
         err_q   <= err_d;
         pass_q  <= pass_d;
      end
   end

   assign in_scan = (state_q == SETTLE) || (state_q == SAMPLE);

   assign {bus.x, bus.y, bus.z, bus.w} = in_scan ? idx_q : '0;
   assign bus.busy      = in_scan;
   assign bus.done      = (state_q == DONE);
   assign bus.table_out = table_q;
   assign bus.err_count = err_q;
   assign bus.pass      = pass_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed bench for truth_table_scanner: default settle (2) and a settle-1 instance.
module tb_truth_table_scanner;

   logic clk;
   logic rst;
   int   total;
   int   bad;
   int   mode_a;

   truth_table_scanner_if ifa ();
   truth_table_scanner_if ifb ();

   truth_table_scanner #(.SETTLE_CYCLES(2)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ifa)
   );

   truth_table_scanner #(.SETTLE_CYCLES(1)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (ifb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stand-in for the downstream function block: 0 golden, 1 tied low, 2 tied high.
   function automatic logic fmodel(input int m, input logic [3:0] v);
      logic [15:0] g;
      g = 16'h32A4;
      case (m)
         1:       return 1'b0;
         2:       return 1'b1;
         default: return g[v];
      endcase
   endfunction

   assign ifa.f_in = fmodel(mode_a, {ifa.x, ifa.y, ifa.z, ifa.w});
   assign ifb.f_in = fmodel(0, {ifb.x, ifb.y, ifb.z, ifb.w});

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, act, exp);
      end
   endtask

   task automatic run_scan(input string tag, input int mode, input bit repulse,
                           input int exp_done, input logic [15:0] exp_tbl,
                           input int exp_err, input bit exp_pass);
      int         done_at;
      int         ndone;
      int         vbad;
      int         bbad;
      logic [3:0] expv;
      mode_a = mode;
      @(negedge clk);
      ifa.start = 1'b1;
      @(posedge clk);
      done_at = -1;
      ndone   = 0;
      vbad    = 0;
      bbad    = 0;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         ifa.start = repulse && (k == 5 || k == 30);
         expv = (k < exp_done) ? 4'((k - 1) / 3) : 4'd0;
         if ({ifa.x, ifa.y, ifa.z, ifa.w} !== expv) vbad++;
         if (ifa.busy !== (k < exp_done)) bbad++;
         if (ifa.done === 1'b1) begin
            ndone++;
            if (done_at < 0) begin
               done_at = k;
               chk({tag, "_tbl"},  32'(ifa.table_out), 32'(exp_tbl));
               chk({tag, "_err"},  32'(ifa.err_count), 32'(exp_err));
               chk({tag, "_pass"}, 32'(ifa.pass),      32'(exp_pass));
            end
         end
      end
      ifa.start = 1'b0;
      chk({tag, "_done_cycle"}, 32'(done_at), 32'(exp_done));
      chk({tag, "_done_count"}, 32'(ndone),   32'd1);
      chk({tag, "_vec_errs"},   32'(vbad),    32'd0);
      chk({tag, "_busy_errs"},  32'(bbad),    32'd0);
      chk({tag, "_held_tbl"},   32'(ifa.table_out), 32'(exp_tbl));
      chk({tag, "_held_pass"},  32'(ifa.pass),      32'(exp_pass));
   endtask

   initial begin
      int dt[3];
      int nd;
      total     = 0;
      bad       = 0;
      mode_a    = 0;
      rst       = 1'b1;
      ifa.start = 1'b0;
      ifb.start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_vec",  32'({ifa.x, ifa.y, ifa.z, ifa.w}), 32'd0);
      chk("rst_busy", 32'(ifa.busy),      32'd0);
      chk("rst_done", 32'(ifa.done),      32'd0);
      chk("rst_tbl",  32'(ifa.table_out), 32'd0);
      chk("rst_err",  32'(ifa.err_count), 32'd0);
      chk("rst_pass", 32'(ifa.pass),      32'd0);
      rst = 1'b0;

      run_scan("golden", 0, 1'b0, 49, 16'h32A4, 0, 1'b1);
`ifdef SCAN_ABORT_ON_MISMATCH_EN
      run_scan("tie0", 1, 1'b0, 10, 16'h0000, 1, 1'b0);
      run_scan("tie1", 2, 1'b0, 4,  16'h0001, 1, 1'b0);
`else
      run_scan("tie0", 1, 1'b0, 49, 16'h0000, 6,  1'b0);
      run_scan("tie1", 2, 1'b0, 49, 16'hFFFF, 10, 1'b0);
`endif
      run_scan("repulse", 0, 1'b1, 49, 16'h32A4, 0, 1'b1);

      // Reset during the SETTLE phase of vector 7.
      mode_a = 0;
      @(negedge clk);
      ifa.start = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 22; k++) begin
         @(negedge clk);
         ifa.start = 1'b0;
      end
      chk("mid_vec", 32'({ifa.x, ifa.y, ifa.z, ifa.w}), 32'd7);
      chk("mid_tbl", 32'(ifa.table_out), 32'h24);
      rst = 1'b1;
      @(negedge clk);
      chk("mrst_vec",  32'({ifa.x, ifa.y, ifa.z, ifa.w}), 32'd0);
      chk("mrst_busy", 32'(ifa.busy),      32'd0);
      chk("mrst_done", 32'(ifa.done),      32'd0);
      chk("mrst_tbl",  32'(ifa.table_out), 32'd0);
      chk("mrst_err",  32'(ifa.err_count), 32'd0);
      chk("mrst_pass", 32'(ifa.pass),      32'd0);
      rst = 1'b0;
      run_scan("post_rst", 0, 1'b0, 49, 16'h32A4, 0, 1'b1);

      // Settle-1 instance with start held high: back-to-back scans every 34 cycles.
      @(negedge clk);
      ifb.start = 1'b1;
      @(posedge clk);
      nd = 0;
      for (int k = 1; k <= 110; k++) begin
         @(negedge clk);
         if (ifb.done === 1'b1) begin
            if (nd < 3) dt[nd] = k;
            nd++;
         end
         if (k == 33) begin
            chk("b2b_tbl",  32'(ifb.table_out), 32'h32A4);
            chk("b2b_err",  32'(ifb.err_count), 32'd0);
            chk("b2b_pass", 32'(ifb.pass),      32'd1);
         end
         if (k == 34) chk("b2b_hold_pass", 32'(ifb.pass), 32'd1);
         if (k == 35) begin
            chk("b2b_clr_tbl",  32'(ifb.table_out), 32'd0);
            chk("b2b_clr_pass", 32'(ifb.pass),      32'd0);
            chk("b2b_busy",     32'(ifb.busy),      32'd1);
         end
      end
      ifb.start = 1'b0;
      chk("b2b_ndone", 32'(nd), 32'd3);
      if (nd >= 3) begin
         chk("b2b_done0", 32'(dt[0]), 32'd33);
         chk("b2b_done1", 32'(dt[1]), 32'd67);
         chk("b2b_done2", 32'(dt[2]), 32'd101);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/truth_table_scanner.md
Name: truth_table_scanner

Overview:
Sequential stimulus and capture stage that sits directly upstream of the 4-input combinational function block. It drives the block's x,y,z,w inputs through all 16 combinations and samples the block's output into a 16-bit truth table. It then checks the table against a golden constant and reports pass/fail. It replaces manual switch toggling on the board.

Parameters:
- SETTLE_CYCLES, 2, cycles inputs are held stable before sampling f_in; legal range 1..15, 0 is illegal (elaboration assert).
- EXPECTED, 16'h32A4, golden truth table; bit i = expected f for {x,y,z,w} = i, x is MSB.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- start  input  1  level; sampled only in IDLE
- f_in  input  1  function output from the downstream function block
- x  output  1  vector bit 3 (MSB), to the function block
- y  output  1  vector bit 2
- z  output  1  vector bit 1
- w  output  1  vector bit 0
- busy  output  1  high in SETTLE and SAMPLE
- done  output  1  one-cycle pulse when the scan ends
- table_out  output  16  captured truth table; bit i = f_in sampled at vector i
- err_count  output  5  number of mismatching bits, 0..16
- pass  output  1  err_count==0; valid from done, held until next start

Behaviour:
- Reset (sync, rst=1 at edge):
  - state=IDLE; idx=0; x,y,z,w=0; busy=0; done=0.
  - table_out=0; err_count=0; pass=0; settle counter=0.
  - rst has priority over everything, including mid-scan; no partial result is retained.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - Outputs hold the last results.
  - start=1 → SETTLE; idx=0; cnt=0; table_out=0; err_count=0; pass=0.
- SETTLE:
  - {x,y,z,w}=idx; lasts exactly SETTLE_CYCLES cycles (cnt counts 0..SETTLE_CYCLES-1), then → SAMPLE.
- SAMPLE:
  - One cycle; inputs still driven with idx.
  - At the closing edge: table_out[idx]<=f_in; if f_in!=EXPECTED[idx], err_count<=err_count+1.
  - idx<15 → idx<=idx+1, cnt<=0, → SETTLE.
  - idx==15 → DONE.
- DONE:
  - One cycle; done=1; pass=(err_count==0) with the final count included.
  - → IDLE; x,y,z,w return to 0 in IDLE.
- Latency: start sampled at edge E0; done high during cycle 16*(SETTLE_CYCLES+1)+1 after E0. With the default this is cycle 49.
- start while busy or in DONE is ignored; there is no queuing.
- start held high continuously: a new scan begins on the cycle after DONE.
- idx is 4 bits and never wraps past 15 within a scan.
- err_count is 5 bits and saturates naturally at 16 (maximum possible).
- f_in is treated as combinational from x,y,z,w; no synchroniser is required.

Optional Feature:
- Macro SCAN_ABORT_ON_MISMATCH_EN.
- Defined: the first mismatch in SAMPLE goes directly to DONE.
  - table_out holds the bits captured so far; later bits stay 0.
  - err_count=1; pass=0.
  - done fires (idx+1)*(SETTLE_CYCLES+1)+1 cycles after start.
- Undefined: always a full 16-vector scan, as above.
- Ports are identical in both builds.

Decomposition:
- Package scan_pkg:
  - state enum scan_state_t {IDLE, SETTLE, SAMPLE, DONE};
  - localparams VEC_W=4, NUM_VEC=16, CNT_W=4;
  - constant GOLDEN_TT=16'h32A4, the default for EXPECTED.
- Sub-module scan_settle_timer: load/enable counter with terminal-count output, width CNT_W. The FSM, capture and compare stay in the top module.

Test Plan:
- Golden function model on f_in, SETTLE_CYCLES=2, start pulse → done at cycle 49; table_out=16'h32A4, err_count=0, pass=1; x,y,z,w step 0000→1111 with each vector held 3 cycles.
- f_in tied 0 → table_out=16'h0000, err_count=6, pass=0. f_in tied 1 → table_out=16'hFFFF, err_count=10, pass=0.
- start re-pulsed at cycles 5 and 30 during a scan → ignored; single done at 49; results identical to the first scenario.
- rst asserted during SETTLE of idx=7 → next cycle: IDLE, all outputs 0. A subsequent start gives a clean scan with table_out=16'h32A4.
- SETTLE_CYCLES=1, start held high → back-to-back scans with done every 34 cycles; results are cleared at each new start.
- SCAN_ABORT_ON_MISMATCH_EN, f_in tied 1 → mismatch at idx 0; done at cycle 4 (SETTLE_CYCLES=2); table_out=16'h0001, err_count=1, pass=0.
